// File: rtl/timer_pkg.sv
// Shared types and constants for the mm:ss timer and its seven-segment decoders.
package timer_pkg;

   typedef enum logic [1:0] {
      IDLE    = 2'd0,
      RUN     = 2'd1,
      PAUSE   = 2'd2,
      EXPIRED = 2'd3
   } state_t;

   localparam logic [5:0] SEC_MAX = 6'd59;

   // Segment order is a..g, index 0 = segment a, active high.
   localparam logic [0:6] SEG_BLANK = 7'b0000000;
   localparam logic [0:6] SEG_0     = 7'b1111110;
   localparam logic [0:6] SEG_1     = 7'b0110000;
   localparam logic [0:6] SEG_2     = 7'b1101101;
   localparam logic [0:6] SEG_3     = 7'b1111001;
   localparam logic [0:6] SEG_4     = 7'b0110011;
   localparam logic [0:6] SEG_5     = 7'b1011011;
   localparam logic [0:6] SEG_6     = 7'b1011111;
   localparam logic [0:6] SEG_7     = 7'b1110000;
   localparam logic [0:6] SEG_8     = 7'b1111111;
   localparam logic [0:6] SEG_9     = 7'b1111011;

endpackage

// File: rtl/seg7_decode.sv
// BCD digit to seven-segment pattern, with a blank override.
module seg7_decode
   import timer_pkg::*;
(
   input  logic [3:0] digit,
   input  logic       blank,
   output logic [0:6] seg
);

   // Digit lookup; out-of-range codes and blank show nothing.
   always_comb begin
      seg = SEG_BLANK;
      if (!blank) begin
         case (digit)
            4'd0:    seg = SEG_0;
            4'd1:    seg = SEG_1;
            4'd2:    seg = SEG_2;
            4'd3:    seg = SEG_3;
            4'd4:    seg = SEG_4;
            4'd5:    seg = SEG_5;
            4'd6:    seg = SEG_6;
            4'd7:    seg = SEG_7;
            4'd8:    seg = SEG_8;
            4'd9:    seg = SEG_9;
            default: seg = SEG_BLANK;
         endcase
      end
   end

endmodule

// File: rtl/mm_ss_timer.sv
// Minutes:seconds count-down / count-up timer with pause, clear and done pulse.
// Optional feature macro TIMER_ALARM_EN: adds an alarm output and blinks the
// display while EXPIRED.
module mm_ss_timer
   import timer_pkg::*;
#(
   parameter int unsigned CLK_HZ  = 50_000_000,
   parameter int unsigned MAX_MIN = 59
) (
   input  logic       clk,
   input  logic       reset,
   input  logic       mode_en,
   input  logic       start,
   input  logic       clear,
   input  logic       set_sec,
   input  logic       set_min,
   input  logic       dir,
   output logic [0:6] seg0,
   output logic [0:6] seg1,
   output logic [0:6] seg2,
   output logic [0:6] seg3,
   output logic       running,
`ifdef TIMER_ALARM_EN
   output logic       alarm,
`endif
   output logic       done
);

   localparam int unsigned MIN_W  = $clog2(MAX_MIN + 1);
   localparam int unsigned MIN_SW = MIN_W + 1;
   localparam int unsigned CNT_W  = $clog2(CLK_HZ);
   localparam logic [MIN_W-1:0] MIN_MAX  = MIN_W'(MAX_MIN);
   localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(CLK_HZ - 1);
`ifdef TIMER_ALARM_EN
   localparam logic [CNT_W-1:0] CNT_HALF = CNT_W'(CLK_HZ / 2);
`endif

   logic [3:0] sync1, sync2, sync3;
   logic [3:0] btn_rise;
   logic       ev_start, ev_clear, ev_sec, ev_min;

   state_t           state_q, state_d;
   logic [5:0]       sec_q, sec_d;
   logic [MIN_W-1:0] min_q, min_d;
   logic [CNT_W-1:0] cnt_q, cnt_d;
   logic             dir_q, dir_d;
   logic             carry;
   logic [MIN_SW-1:0] min_sum;

   logic [3:0] sec_ones, sec_tens, min_ones, min_tens;
   logic [6:0] min_ext;
   logic       blank;

   // Button synchronisers and edge history run regardless of mode_en.
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         sync1 <= '0;
         sync2 <= '0;
         sync3 <= '0;
      end else begin
         sync1 <= {start, clear, set_sec, set_min};
         sync2 <= sync1;
         sync3 <= sync2;
      end
   end

   // Rising edges, discarded while the block is disabled.
   assign btn_rise = sync2 & ~sync3 & {4{mode_en}};
   assign ev_start = btn_rise[3];
   assign ev_clear = btn_rise[2];
   assign ev_sec   = btn_rise[1];
   assign ev_min   = btn_rise[0];

   // State, time, tick counter and registered status outputs.
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         state_q <= IDLE;
         sec_q   <= '0;
         min_q   <= '0;
         cnt_q   <= '0;
         dir_q   <= 1'b0;
         running <= 1'b0;
         done    <= 1'b0;
`ifdef TIMER_ALARM_EN
         alarm   <= 1'b0;
`endif
      end else begin
         state_q <= state_d;
         sec_q   <= sec_d;
         min_q   <= min_d;
         cnt_q   <= cnt_d;
         dir_q   <= dir_d;
         running <= (state_d == RUN);
         done    <= (state_d == EXPIRED) && (state_q != EXPIRED);
`ifdef TIMER_ALARM_EN
         alarm   <= (state_d == EXPIRED);
`endif
      end
   end

   // Next state and datapath; everything holds while mode_en is low.
   always_comb begin
      state_d = state_q;
      sec_d   = sec_q;
      min_d   = min_q;
      cnt_d   = cnt_q;
      dir_d   = dir_q;
      carry   = 1'b0;
      min_sum = '0;
      if (mode_en) begin
         if (ev_clear) begin
            state_d = IDLE;
            sec_d   = '0;
            min_d   = '0;
            cnt_d   = '0;
         end else begin
            case (state_q)
               IDLE: begin
                  cnt_d = '0;
                  if (ev_start) begin
                     if (dir || (sec_q != 6'd0) || (min_q != '0)) begin
                        state_d = RUN;
                        dir_d   = dir;
                     end
                  end else if (ev_sec || ev_min) begin
                     if (ev_sec && !((min_q == MIN_MAX) && (sec_q == SEC_MAX))) begin
                        if (sec_q == SEC_MAX) begin
                           sec_d = '0;
                           carry = 1'b1;
                        end else begin
                           sec_d = sec_q + 6'd1;
                        end
                     end
                     min_sum = MIN_SW'(min_q) + MIN_SW'(ev_min) + MIN_SW'(carry);
                     min_d = (min_sum > MIN_SW'(MAX_MIN)) ? MIN_MAX : min_sum[MIN_W-1:0];
                  end
               end
               RUN: begin
                  if (ev_start) begin
                     state_d = PAUSE;
                  end else if (cnt_q != CNT_LAST) begin
                     cnt_d = cnt_q + CNT_W'(1);
                  end else begin
                     cnt_d = '0;
                     if (dir_q) begin
                        if ((min_q == MIN_MAX) && (sec_q == SEC_MAX)) begin
                           state_d = EXPIRED;
                        end else begin
                           if (sec_q == SEC_MAX) begin
                              sec_d = '0;
                              min_d = min_q + MIN_W'(1);
                           end else begin
                              sec_d = sec_q + 6'd1;
                           end
                           if ((min_d == MIN_MAX) && (sec_d == SEC_MAX)) state_d = EXPIRED;
                        end
                     end else begin
                        if ((min_q == '0) && (sec_q == 6'd0)) begin
                           state_d = EXPIRED;
                        end else begin
                           if (sec_q == 6'd0) begin
                              sec_d = SEC_MAX;
                              min_d = min_q - MIN_W'(1);
                           end else begin
                              sec_d = sec_q - 6'd1;
                           end
                           if ((min_d == '0) && (sec_d == 6'd0)) state_d = EXPIRED;
                        end
                     end
                  end
               end
               PAUSE: begin
                  if (ev_start) state_d = RUN;
               end
               EXPIRED: begin
                  if (ev_start) begin
                     state_d = IDLE;
                     cnt_d   = '0;
                  end else begin
`ifdef TIMER_ALARM_EN
                     cnt_d = (cnt_q == CNT_LAST) ? '0 : cnt_q + CNT_W'(1);
`else
                     cnt_d = '0;
`endif
                  end
               end
               default: state_d = IDLE;
            endcase
         end
      end
   end

   // Display digits and blink blanking, straight from the time registers.
   always_comb begin
      min_ext  = 7'(min_q);
      sec_ones = 4'(sec_q % 6'd10);
      sec_tens = 4'(sec_q / 6'd10);
      min_ones = 4'(min_ext % 7'd10);
      min_tens = 4'(min_ext / 7'd10);
      blank    = 1'b0;
`ifdef TIMER_ALARM_EN
      blank    = (state_q == EXPIRED) && (cnt_q < CNT_HALF);
`endif
   end

   seg7_decode u_seg0 (.digit(sec_ones), .blank(blank), .seg(seg0));
   seg7_decode u_seg1 (.digit(sec_tens), .blank(blank), .seg(seg1));
   seg7_decode u_seg2 (.digit(min_ones), .blank(blank), .seg(seg2));
   seg7_decode u_seg3 (.digit(min_tens), .blank(blank), .seg(seg3));

endmodule

// File: tb/tb_mm_ss_timer.sv
// Scoreboard bench for mm_ss_timer with CLK_HZ = 4, MAX_MIN = 2.
module tb_mm_ss_timer;

   localparam int unsigned CLK_HZ  = 4;
   localparam int unsigned MAX_MIN = 2;
`ifdef TIMER_ALARM_EN
   localparam bit ALARM = 1'b1;
`else
   localparam bit ALARM = 1'b0;
`endif

   logic clk = 1'b0;
   logic reset, mode_en, start, clear, set_sec, set_min, dir;
   logic [0:6] seg0, seg1, seg2, seg3;
   logic running, done;
`ifdef TIMER_ALARM_EN
   logic alarm;
`endif

   typedef struct packed {
      logic        run;
      logic        dn;
      logic [27:0] seg;
   } obs_t;

   obs_t exp_q[$];
   int   checks = 0;
   int   errors = 0;
   int   done_cnt = 0;

   mm_ss_timer #(.CLK_HZ(CLK_HZ), .MAX_MIN(MAX_MIN)) dut (
      .clk(clk), .reset(reset), .mode_en(mode_en), .start(start), .clear(clear),
      .set_sec(set_sec), .set_min(set_min), .dir(dir),
      .seg0(seg0), .seg1(seg1), .seg2(seg2), .seg3(seg3),
      .running(running),
`ifdef TIMER_ALARM_EN
      .alarm(alarm),
`endif
      .done(done)
   );

   always #5 clk = ~clk;

   always @(negedge clk) if (done === 1'b1) done_cnt++;

   function automatic logic [6:0] pat(input int d);
      case (d)
         0: return 7'b1111110;
         1: return 7'b0110000;
         2: return 7'b1101101;
         3: return 7'b1111001;
         4: return 7'b0110011;
         5: return 7'b1011011;
         6: return 7'b1011111;
         7: return 7'b1110000;
         8: return 7'b1111111;
         9: return 7'b1111011;
         default: return 7'b0000000;
      endcase
   endfunction

   function automatic logic [27:0] disp(input int mm, input int ss, input bit blank);
      if (blank) return 28'd0;
      return {pat(mm / 10), pat(mm % 10), pat(ss / 10), pat(ss % 10)};
   endfunction

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      checks++;
      if (got !== exp) begin
         errors++;
         $display("FAIL %s: got %h expected %h", tag, got, exp);
      end
   endtask

   task automatic push_exp(input int mm, input int ss, input bit blank, input bit run, input bit dn);
      obs_t e;
      e.run = run;
      e.dn  = dn;
      e.seg = disp(mm, ss, blank);
      exp_q.push_back(e);
   endtask

   task automatic pop_check(input string tag);
      obs_t e;
      if (exp_q.size() == 0) begin
         check({tag, "_empty"}, 32'd1, 32'd0);
      end else begin
         e = exp_q.pop_front();
         check(tag, {2'b00, running, done, seg3, seg2, seg1, seg0}, {2'b00, e});
      end
   endtask

   task automatic step(input int n);
      repeat (n) @(posedge clk);
      #1;
   endtask

   // b = {start, clear, set_sec, set_min}; returns once the event has been applied.
   task automatic press(input logic [3:0] b);
      {start, clear, set_sec, set_min} = b;
      step(1);
      {start, clear, set_sec, set_min} = 4'b0000;
      step(2);
   endtask

   initial begin
      reset = 1'b0; mode_en = 1'b1; dir = 1'b0;
      {start, clear, set_sec, set_min} = 4'b0000;
      step(2);
      push_exp(0, 0, 0, 0, 0);
      pop_check("in_reset");
      reset = 1'b1;
      step(1);
      push_exp(0, 0, 0, 0, 0);
      pop_check("after_reset");

      // Countdown from 01:02 to expiry
      push_exp(1, 2, 0, 0, 0);
      press(4'b0001);
      press(4'b0010);
      press(4'b0010);
      pop_check("set_0102");
      dir = 1'b0;
      done_cnt = 0;
      push_exp(1, 2, 0, 1, 0);
      press(4'b1000);
      pop_check("down_entry");
      push_exp(1, 1, 0, 1, 0); step(4); pop_check("down_1");
      push_exp(1, 0, 0, 1, 0); step(4); pop_check("down_2");
      push_exp(0, 59, 0, 1, 0); step(4); pop_check("down_borrow");
      push_exp(0, 1, 0, 1, 0); step(59 * 4 - 1); pop_check("down_last");
      push_exp(0, 0, ALARM, 0, 1); step(1); pop_check("expire");
      push_exp(0, 0, ALARM, 0, 0); step(1); pop_check("expire_1");
      push_exp(0, 0, 0, 0, 0); step(1); pop_check("expire_2");
      push_exp(0, 0, 0, 0, 0); step(1); pop_check("expire_3");
      push_exp(0, 0, ALARM, 0, 0); step(1); pop_check("expire_4");
`ifdef TIMER_ALARM_EN
      check("alarm_on", alarm, 1);
`endif
      check("done_pulses", done_cnt, 1);
      push_exp(0, 0, 0, 0, 0);
      press(4'b1000);
      pop_check("expired_start");
`ifdef TIMER_ALARM_EN
      check("alarm_off", alarm, 0);
`endif

      // Setting, carry and saturation
      push_exp(0, 59, 0, 0, 0);
      repeat (59) press(4'b0010);
      pop_check("set_0059");
      push_exp(1, 0, 0, 0, 0); press(4'b0010); pop_check("sec_carry");
      push_exp(1, 59, 0, 0, 0);
      repeat (59) press(4'b0010);
      pop_check("set_0159");
      push_exp(2, 0, 0, 0, 0); press(4'b0011); pop_check("both_sat");
      push_exp(2, 59, 0, 0, 0);
      repeat (59) press(4'b0010);
      pop_check("set_0259");
      push_exp(2, 59, 0, 0, 0); press(4'b0010); pop_check("max_sec");
      push_exp(2, 59, 0, 0, 0); press(4'b0001); pop_check("max_min");
      push_exp(0, 0, 0, 0, 0); press(4'b0100); pop_check("clear_idle");

      // Count up, pause, resume
      dir = 1'b1;
      push_exp(0, 0, 0, 1, 0); press(4'b1000); pop_check("up_entry");
      push_exp(0, 1, 0, 1, 0); step(4); pop_check("up_1");
      push_exp(0, 1, 0, 0, 0); press(4'b1000); pop_check("pause");
      push_exp(0, 1, 0, 0, 0); step(20); pop_check("pause_hold");
      push_exp(0, 1, 0, 1, 0); press(4'b1000); pop_check("resume");
      push_exp(0, 1, 0, 1, 0); step(1); pop_check("resume_1");
      push_exp(0, 2, 0, 1, 0); step(1); pop_check("resume_tick");

      // clear beats start
      push_exp(0, 0, 0, 0, 0); press(4'b1100); pop_check("clear_start");
      push_exp(0, 0, 0, 0, 0); step(8); pop_check("clear_hold");

      // mode_en freeze; a clear while disabled is dropped
      push_exp(0, 0, 0, 1, 0); press(4'b1000); pop_check("en_entry");
      step(2);
      mode_en = 1'b0;
      clear = 1'b1;
      step(1);
      clear = 1'b0;
      push_exp(0, 0, 0, 1, 0); step(9); pop_check("freeze");
      mode_en = 1'b1;
      push_exp(0, 0, 0, 1, 0); step(1); pop_check("unfreeze_1");
      push_exp(0, 1, 0, 1, 0); step(1); pop_check("unfreeze_tick");

      // Asynchronous reset mid-run
      push_exp(0, 37, 0, 1, 0); step(36 * 4); pop_check("up_0037");
      #2;
      reset = 1'b0;
      #1;
      push_exp(0, 0, 0, 0, 0); pop_check("async_reset");
      @(posedge clk);
      #1;
      reset = 1'b1;
      dir = 1'b0;
      push_exp(0, 0, 0, 0, 0); press(4'b1000); pop_check("start_zero");
      push_exp(0, 0, 0, 0, 0); step(8); pop_check("start_zero_hold");

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule

// File: doc/mm_ss_timer.md
# mm_ss_timer

Parametrised minutes:seconds timer for the digital-clock board, driving four seven-segment digits (SS ones, SS tens, MM ones, MM tens). Next generation of the countdown timer mode:
- adds count-up (stopwatch) direction, pause/resume, synchronous clear and a done pulse;
- clock rate and minute ceiling are parameters.

Sits beside the clock and alarm modes, gated by the top-level mode select.

## Interface
- CLK_HZ, 50_000_000, input clock frequency; one timer tick every CLK_HZ cycles (must be ≥ 2)
- MAX_MIN, 59, minute ceiling (1..99); bounds setting and count-up
- clk  in  1  system clock
- reset  in  1  asynchronous, active-low; returns block to IDLE, 00:00
- mode_en  in  1  block enable; low freezes all state except input synchronisers
- start  in  1  start/pause/resume button, active-high
- clear  in  1  clear button, active-high
- set_sec  in  1  seconds-set button, active-high
- set_min  in  1  minutes-set button, active-high
- dir  in  1  0 = count down, 1 = count up; latched on IDLE→RUN
- seg0..seg3  out  [0:6]  segment patterns, SS ones..MM tens
- running  out  1  high in RUN
- done  out  1  one-cycle pulse on entry to EXPIRED

## Operation
- Buttons: 2-flop synchroniser, then rising-edge detect. Events are acted on only when mode_en = 1; events arriving while mode_en = 0 are dropped.
- Priority within a cycle: clear > start > set_min/set_sec.
- clear: from any state go to IDLE, time 00:00, tick counter 0.
- IDLE:
  - set_sec: sec+1; 59 wraps to 0 and carries into min.
  - set_min: min+1.
  - Minute increment = set_min + carry, saturating at MAX_MIN. Both set buttons in the same cycle apply together.
  - At MAX_MIN:59, set_sec has no effect.
  - start: latch dir, go to RUN. A countdown start at 00:00 is ignored.
- RUN:
  - Tick counter runs 0..CLK_HZ-1; a tick fires when the counter equals CLK_HZ-1.
  - Down: decrement with borrow (m:00 → (m-1):59). Reaching 00:00 → EXPIRED.
  - Up: increment with carry. Reaching MAX_MIN:59 → EXPIRED.
  - start → PAUSE. Set buttons are ignored.
- PAUSE: tick counter and time held; start → RUN, resuming the partial second; set buttons ignored.
- EXPIRED: time held; start or clear → IDLE. Time is kept on start and zeroed on clear.
- Widths:
  - sec: 6 bits.
  - min: $clog2(MAX_MIN+1) bits.
  - tick counter: $clog2(CLK_HZ) bits.
- Display digits are value % 10 and value / 10.

## Timing
- Reset values: state IDLE, sec = 0, min = 0, counter = 0, running = 0, done = 0; seg0..seg3 show "0".
- Button rise to time/state register update: 3 clk cycles (2 sync + edge).
- seg outputs are combinational from the time registers, so they follow an update in the same cycle.
- done asserts in the cycle after the final tick, coincident with the state register showing EXPIRED, for exactly 1 cycle.
- running is registered and valid in the same cycle as the state.
- The first tick after RUN entry from IDLE occurs CLK_HZ cycles after entry.
- mode_en low mid-RUN: counter and time are frozen. On re-enable, counting resumes with no lost cycles.
- Reset asserted mid-operation takes effect immediately, independent of clk; deassertion is synchronous to clk.

## Configuration
- TIMER_ALARM_EN defined:
  - Adds output `alarm` (1 bit), high throughout EXPIRED.
  - In EXPIRED, all four digits blink: blank for the first CLK_HZ/2 cycles of each second, then show the time. The tick counter keeps running in EXPIRED for this purpose.
- TIMER_ALARM_EN undefined: no alarm port, no blinking, and the tick counter is held at 0 in EXPIRED.

## Structure
- Package timer_pkg holds:
  - the state enum (IDLE, RUN, PAUSE, EXPIRED);
  - SEG_BLANK and the digit 0–9 segment constants;
  - SEC_MAX = 59.
- Sub-module seg7_decode: 4-bit digit plus blank input → [0:6] pattern, instantiated 4×.

## Test plan
- CLK_HZ = 4. Set 01:02 via 1×set_min and 2×set_sec, start with dir = 0 → display steps 01:01, 01:00, 00:59 every 4 cycles. At 00:00: done pulses once, running = 0.
- Set 00:59, pulse set_sec → 01:00. With MAX_MIN = 2 at 02:59, set_sec or set_min → stays 02:59.
- Start dir = 1 from 00:00, pause after 6 cycles, wait 20 cycles → display 00:01 held. Resume → 00:02 exactly 2 cycles later.
- clear and start on the same cycle during RUN → IDLE at 00:00, running = 0.
- Reset low mid-RUN at 00:37 → immediately 00:00 and IDLE; start at 00:00 with dir = 0 → stays IDLE.
- TIMER_ALARM_EN defined: at expiry, alarm = 1 and digits are blank for 2 cycles then lit for 2, repeating. start → alarm = 0, state IDLE.
